// File: rtl/display_multiplexado.sv
// Time-multiplexed driver for N common-anode 7-segment digits.
// Optional blink support is enabled by defining DISPLAY_PISCA_EN.
module display_multiplexado #(
   parameter int N_DIGITOS   = 4,
   parameter int DIV_REFRESH = 50000,
   parameter int DIV_PISCA   = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   liga,
   input  logic [4*N_DIGITOS-1:0] digitos,
   input  logic [N_DIGITOS-1:0]   pontos,
   input  logic [N_DIGITOS-1:0]   apagado,
   input  logic [N_DIGITOS-1:0]   pisca,
   output logic [6:0]             segmentos,
   output logic                   dp,
   output logic [N_DIGITOS-1:0]   anodos,
   output logic                   fim_quadro
);

   localparam int CW = $clog2(DIV_REFRESH);
   localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
   localparam logic [CW-1:0] ULT_PRE = CW'(DIV_REFRESH - 1);
   localparam logic [IW-1:0] ULT_DIG = IW'(N_DIGITOS - 1);

   logic [CW-1:0]          cnt_pre;
   logic [IW-1:0]          indice;
   logic [4*N_DIGITOS-1:0] snap_dig;
   logic [N_DIGITOS-1:0]   snap_pt;
   logic [N_DIGITOS-1:0]   snap_apag;

   logic                   tick;
   logic                   wrap;
   logic                   oculto;
   logic [6:0]             nx_seg;
   logic                   nx_dp;
   logic [N_DIGITOS-1:0]   nx_an;

   function automatic logic [6:0] decode(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = liga && (cnt_pre == ULT_PRE);
   assign wrap = tick && (indice == ULT_DIG);

`ifdef DISPLAY_PISCA_EN
   localparam int QW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;
   localparam logic [QW-1:0] ULT_Q = QW'(DIV_PISCA - 1);

   logic [QW-1:0]        cnt_quadro;
   logic                 fase;
   logic [N_DIGITOS-1:0] snap_pisca;

   // Phase flips on the frame boundary, together with the snapshot.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_quadro <= '0;
         fase       <= 1'b0;
         snap_pisca <= '0;
      end else if (wrap) begin
         snap_pisca <= pisca;
         if (cnt_quadro == ULT_Q) begin
            cnt_quadro <= '0;
            fase       <= ~fase;
         end else begin
            cnt_quadro <= cnt_quadro + 1'b1;
         end
      end
   end

   assign oculto = fase & snap_pisca[indice];
`else
   logic unused_pisca;
   assign unused_pisca = ^pisca;
   assign oculto = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_pre <= '0;
         indice  <= '0;
      end else if (!liga) begin
         cnt_pre <= '0;
         indice  <= '0;
      end else if (tick) begin
         cnt_pre <= '0;
         indice  <= wrap ? '0 : indice + 1'b1;
      end else begin
         cnt_pre <= cnt_pre + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         snap_dig  <= '0;
         snap_pt   <= '0;
         snap_apag <= '1;
      end else if (wrap) begin
         snap_dig  <= digitos;
         snap_pt   <= pontos;
         snap_apag <= apagado;
      end
   end

   // The tick cycle is forced dark so the old digit never ghosts into the next.
   always_comb begin
      nx_seg = 7'h7F;
      nx_dp  = 1'b1;
      nx_an  = '1;
      if (liga && !tick) begin
         nx_an[indice] = 1'b0;
         if (!(snap_apag[indice] || oculto)) begin
            nx_seg = decode(snap_dig[4*indice +: 4]);
            nx_dp  = ~snap_pt[indice];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         segmentos  <= 7'h7F;
         dp         <= 1'b1;
         anodos     <= '1;
         fim_quadro <= 1'b0;
      end else begin
         segmentos  <= nx_seg;
         dp         <= nx_dp;
         anodos     <= nx_an;
         fim_quadro <= wrap;
      end
   end

endmodule

// File: doc/display_multiplexado.md
Name: display_multiplexado

Overview:
Parametrised time-multiplexed driver for N common-anode 7-segment digits. Generalises the fixed 4-digit display path: configurable digit count and refresh rate, per-digit decimal point and blank mask, frame-coherent input snapshot, and inter-digit dead time against ghosting. Sits between game logic (modo/coordinate/mapa values) and the board's segment and digit-select pins.

Parameters:
N_DIGITOS, 4, number of multiplexed digits (1..8)
DIV_REFRESH, 50000, clock cycles per digit slot (>= 2)
DIV_PISCA, 64, frames per blink half-period (>= 1; used only with the optional feature)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
liga  input  1  display enable; 0 = all digits dark
digitos  input  4*N_DIGITOS  hex code per digit; digit i = bits [4i+3:4i]
pontos  input  N_DIGITOS  decimal point request per digit, 1 = lit
apagado  input  N_DIGITOS  per-digit blank mask, 1 = digit dark
pisca  input  N_DIGITOS  per-digit blink request (ignored without the optional feature)
segmentos  output  7  {g,f,e,d,c,b,a}, active-low, registered
dp  output  1  decimal point, active-low, registered
anodos  output  N_DIGITOS  digit select, active-low, one-hot-cold, registered
fim_quadro  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset (reset=1 at a clock edge): cnt_pre=0, indice=0; snapshot digitos=0, pontos=0, apagado=all 1; segmentos=7'h7F, dp=1, anodos=all 1, fim_quadro=0; blink phase=0.
- Prescaler: cnt_pre counts 0..DIV_REFRESH-1, then wraps. tick = (cnt_pre == DIV_REFRESH-1).
- Scan: on tick, indice <= (indice == N_DIGITOS-1) ? 0 : indice+1.
- Snapshot: on a tick where indice wraps N_DIGITOS-1 -> 0, digitos/pontos/apagado are captured, and fim_quadro=1 in the following cycle. Input changes mid-frame never appear until the next frame.
- Output register (1-cycle latency): on a tick cycle, outputs load all-off (dead time). Otherwise anodos[indice]=0, remaining bits 1; segmentos=decode(snapshot digit indice); dp=~snapshot pontos[indice]. If snapshot apagado[indice]=1, segmentos=7'h7F, dp=1, and anodos stay active.
- Each digit is lit DIV_REFRESH-1 cycles per slot, followed by 1 dark cycle. Frame length = N_DIGITOS*DIV_REFRESH cycles.
- Decode (active-low, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- liga=0: cnt_pre and indice held at 0; outputs all off; fim_quadro=0; snapshot held. On liga rising, scanning restarts from digit 0 exactly as after reset, except the snapshot keeps its held contents.
- N_DIGITOS=1: indice stays 0; every tick is a wrap, so a snapshot is taken every slot.
- Reset mid-frame: everything returns to reset values at that edge, regardless of liga.

Optional Feature:
DISPLAY_PISCA_EN defined: a frame counter toggles blink phase every DIV_PISCA frames (counted at fim_quadro). pisca is captured with the snapshot. While phase=1, digits with snapshot pisca=1 are output as blanked (segments and dp off).
Not defined: no blink counter or phase register is synthesised; pisca is ignored; behaviour is otherwise identical.

Test Plan:
N=4, DIV_REFRESH=4, reset released at cycle 0 -> anodos=4'b1111 and segmentos=7'h7F through first frame (blank snapshot); fim_quadro=1 at cycle 16.
digitos=16'h4321, pontos=4'b0001, apagado=0 held -> second frame: cycles 17-19 anodos=1110, segmentos=7'h79, dp=0; cycle 20 all off; cycles 21-23 anodos=1101, segmentos=7'h24, dp=1.
Change digitos to 16'hFFFF at cycle 22 -> digits 2-3 still show 3 and 4 in the current frame; all show 7'h0E from the next frame.
apagado=4'b0100 -> digit 2 slot: anodos=1011, segmentos=7'h7F, dp=1.
liga=0 for 10 cycles mid-frame, then 1 -> anodos=all 1 during; restart at digit 0, 1 cycle after liga rises; reset pulse mid-scan -> all outputs return to reset values on the next edge.
With DISPLAY_PISCA_EN, DIV_PISCA=2, pisca=4'b0001 -> digit 0 is lit for frames 1-2 and dark for frames 3-4, while the other digits are unaffected. Without the macro, digit 0 is always lit.
